// File: rtl/pulse_catcher.sv
// pulse_catcher: captures rising edges on an asynchronous net (including pulses narrower
// than a clk period), synchronises them into the clk domain, stretches each event into a
// fixed-width z pulse and counts events with a saturating, sticky-overflow counter.
module pulse_catcher #(
  parameter int unsigned STRETCH = 4,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          clr,
  output logic          z,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam logic [7:0] StretchVal = 8'(STRETCH);

  logic          cap_q;
  logic          cap_clr;
  logic          s1_q, s2_q, s2d_q, ack_q;
  logic          det;
  logic [7:0]    str_q, str_d;
  logic          z_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // Clear of the capture flop; ack dominates so an edge arriving during ack is dropped.
  always_comb begin
    cap_clr = rst | ack_q;
  end

  // Capture flop clocked by the monitored net itself, so sub-period pulses are not missed.
  always_ff @(posedge a or posedge cap_clr) begin
    if (cap_clr) cap_q <= 1'b0;
    else         cap_q <= 1'b1;
  end

  // Two-flop synchroniser plus edge-detect delay; ack is fed back to release the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s2d_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      s1_q  <= cap_q;
      s2_q  <= s1_q;
      s2d_q <= s2_q;
      ack_q <= s2_q;
    end
  end

  // One-cycle event strobe on the synchronised rising edge.
  always_comb begin
    det = s2_q & ~s2d_q;
  end

  // Stretch counter next state: a new event reloads, otherwise count down to zero.
  always_comb begin
    str_d = str_q;
    if (det)                str_d = StretchVal;
    else if (str_q != 8'd0) str_d = str_q - 8'd1;
  end

  // Event counter next state; clr wins but still records a coincident event.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = det ? CW'(1) : '0;
      ovf_d = 1'b0;
    end else if (det) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        ovf_d = ovf_q | (&cnt_d);
      end
    end
  end

  // Stretch, output and counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      str_q <= 8'd0;
      z_q   <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      str_q <= str_d;
      z_q   <= (str_d != 8'd0);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Outputs come straight from registers; a never reaches them combinationally.
  always_comb begin
    z     = z_q;
    count = cnt_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_pulse_catcher.sv
// Randomised bench for pulse_catcher against an event-level reference model.
// Rising edges of a are generated only in the middle of clk periods ("windows"). An edge in
// window n that is accepted becomes an event reported at clk edge n+3, and the catcher is
// blind to further edges during windows n+1..n+5.
`timescale 1ns/1ps
module tb_pulse_catcher;

  localparam int unsigned Stretch = 8;
  localparam int unsigned Cw      = 3;
  localparam int          CntMax  = (1 << Cw) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          a;
  logic          clr;
  logic          z;
  logic          ovf;
  logic [Cw-1:0] count;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  int k;              // index of the most recent clk edge
  int pend;           // clk edge at which the in-flight event is reported, -1 if none
  int blocked_until;  // first window in which a new edge can be accepted
  int last_det;       // clk edge of the most recent reported event
  int m_cnt;
  bit m_ovf;
  bit in_rst;
  int rst_left;
  int rises;

  always #5 clk = ~clk;

  pulse_catcher #(
    .STRETCH(Stretch),
    .CW     (Cw)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .clr  (clr),
    .z    (z),
    .count(count),
    .ovf  (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic set_a(input logic v);
    if (!a && v) rises++;
    a = v;
  endtask

  task automatic model_reset();
    pend          = -1;
    blocked_until = 0;
    last_det      = -1000;
    m_cnt         = 0;
    m_ovf         = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_z"}, 32'(z), 32'((k - last_det) < int'(Stretch)));
    check_eq({tag, "_count"}, 32'(count), 32'(m_cnt));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  initial begin
    logic [2:0] seq;
    int         op;
    bit         det;

    rst      = 1'b1;
    a        = 1'b0;
    clr      = 1'b0;
    in_rst   = 1'b1;
    rst_left = 2;
    k        = 0;
    model_reset();
    #1;
    check_outputs("reset");

    repeat (4000) begin
      @(posedge clk);
      k++;
      // Model the clk edge: report a due event, then apply counter rules.
      if (!in_rst) begin
        det = (pend == k);
        if (det) begin
          pend     = -1;
          last_det = k;
        end
        if (clr) begin
          m_cnt = det ? 1 : 0;
          m_ovf = 1'b0;
        end else if (det) begin
          if (m_cnt == CntMax) begin
            m_ovf = 1'b1;
          end else begin
            m_cnt++;
            if (m_cnt == CntMax) m_ovf = 1'b1;
          end
        end
      end
      #1;
      check_outputs("edge");

      // Window activity on clr and a at +2, +3, +4 ns after the edge.
      #1;
      clr   = ($urandom_range(0, 63) == 0);
      rises = 0;
      op    = int'($urandom_range(0, 15));
      case (op)
        0:       seq = 3'b111;                         // go (or stay) high
        1:       seq = 3'b000;                         // go (or stay) low
        2, 3:    seq = a ? 3'b110 : 3'b001;            // narrow pulse / notch
        4:       seq = 3'b101;                         // two edges, second left high
        5:       seq = 3'b001;                         // single narrow pulse
        default: seq = {a, a, a};
      endcase
      set_a(seq[0]);
      #1;
      set_a(seq[1]);
      #1;
      set_a(seq[2]);
      if (rises > 0 && !in_rst && k >= blocked_until) begin
        pend          = k + 3;
        blocked_until = k + 6;
      end

      // Reset activity at +5 ns, well clear of both clk edges and a transitions.
      #1;
      if (in_rst) begin
        if (rst_left == 0) begin
          rst    = 1'b0;
          in_rst = 1'b0;
        end else begin
          rst_left--;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        rst      = 1'b1;
        in_rst   = 1'b1;
        rst_left = int'($urandom_range(0, 2));
        model_reset();
        #1;
        check_outputs("rst_async");
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
